// File: rtl/udp_tx_pkt_feeder.sv
// udp_tx_pkt_feeder: packs sample bytes into words, buffers them and feeds UDP TX packets
module udp_tx_pkt_feeder #(
  parameter int          FIFO_AW   = 9,
  parameter int          PKT_WORDS = 256,
  parameter logic [15:0] HDR_TAG   = 16'hA55A
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               cap_en,
  input  logic               smp_valid,
  input  logic [7:0]         smp_data,
  output logic               tx_start_en,
  output logic [15:0]        tx_byte_num,
  input  logic               tx_req,
  output logic [31:0]        tx_data,
  input  logic               tx_done,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               ovf_flag,
  input  logic               clr_ovf,
  output logic [15:0]        seq_num,
  output logic               busy
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int IW    = $clog2(PKT_WORDS + 2);
  localparam logic [FIFO_AW:0] PKT_L  = (FIFO_AW + 1)'(PKT_WORDS);
  localparam logic [FIFO_AW:0] FULL_L = (FIFO_AW + 1)'(DEPTH);
  localparam logic [IW-1:0]    LAST   = IW'(PKT_WORDS);
  typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;
  state_t               state_q;
  logic [1:0]           cnt_q;
  logic [23:0]          sh_q;
  logic [31:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wp_q, rp_q;
  logic [FIFO_AW:0]     lvl_q, lvl_d;
  logic                 ovf_q, start_q;
  logic [31:0]          data_q;
  logic [15:0]          seq_q;
  logic [IW-1:0]        idx_q;
  logic                 push, pop, empty, full, byp, do_push, do_pop, ovf_set;
  logic [31:0]          push_word, rd_word;
  // FIFO handshake: a pop at full frees the slot for a same-cycle push; a pop at empty bypasses the incoming word
  always_comb begin
    push      = smp_valid & cap_en & (cnt_q == 2'd3);
    push_word = {sh_q, smp_data};
    pop       = (state_q == SEND) & tx_req & (idx_q != '0);
    empty     = (lvl_q == '0);
    full      = (lvl_q == FULL_L);
    byp       = pop & empty & push;
    do_pop    = pop & ~empty;
    do_push   = push & ~byp & (~full | pop);
    ovf_set   = push & full & ~pop;
    rd_word   = empty ? push_word : mem_q[rp_q];
    lvl_d     = lvl_q + {{FIFO_AW{1'b0}}, do_push} - {{FIFO_AW{1'b0}}, do_pop};
  end
  // byte packer: first byte lands in the MSBs, word completes on the fourth byte
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !cap_en) begin
      cnt_q <= 2'd0;
      sh_q  <= 24'h0;
    end else if (smp_valid) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q  <= {sh_q[15:0], smp_data};
    end
  end
  // FIFO storage; contents are flushed by resetting the pointers
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wp_q] <= push_word;
  end
  // FIFO pointers and exact fill level
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
      lvl_q <= lvl_d;
    end
  end
  // sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge sys_clk) begin
    if (sys_rst) ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (clr_ovf) ovf_q <= 1'b0;
  end
  // packet FSM: start pulse, header then PKT_WORDS popped words, wait for tx_done
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      data_q  <= 32'h0;
      seq_q   <= 16'h0;
      idx_q   <= '0;
    end else begin
      start_q <= 1'b0;
      if (tx_req) data_q <= 32'h0;
      case (state_q)
        IDLE: if (lvl_q >= PKT_L) begin
          state_q <= START;
          start_q <= 1'b1;
        end
        START: begin
          idx_q   <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (tx_req) begin
            data_q <= (idx_q == '0) ? {HDR_TAG, seq_q} : rd_word;
            idx_q  <= idx_q + IW'(1);
            if (idx_q == LAST) state_q <= WAIT_DONE;
          end
          if (tx_done) begin
            seq_q   <= seq_q + 16'd1;
            state_q <= IDLE;
          end
        end
        WAIT_DONE: if (tx_done) begin
          seq_q   <= seq_q + 16'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign tx_start_en = start_q;
  assign tx_byte_num = 16'((PKT_WORDS + 1) * 4);
  assign tx_data     = data_q;
  assign fifo_level  = lvl_q;
  assign ovf_flag    = ovf_q;
  assign seq_num     = seq_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_udp_tx_pkt_feeder.sv
// tb_udp_tx_pkt_feeder: directed bench for the packet feeder with a 4-word FIFO and 4-word packets
module tb_udp_tx_pkt_feeder;
  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cap_en = 1'b0;
  logic        smp_valid = 1'b0;
  logic [7:0]  smp_data = 8'h0;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  logic [2:0]  fifo_level;
  logic        ovf_flag;
  logic [15:0] seq_num;
  logic        busy;
  int          vectors = 0;
  int          errs = 0;
  int          starts = 0;
  int          s0;

  udp_tx_pkt_feeder #(.FIFO_AW(2), .PKT_WORDS(4), .HDR_TAG(16'hA55A)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .cap_en(cap_en), .smp_valid(smp_valid),
    .smp_data(smp_data), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
    .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done), .fifo_level(fifo_level),
    .ovf_flag(ovf_flag), .clr_ovf(clr_ovf), .seq_num(seq_num), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_start_en === 1'b1) starts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    cap_en = 1'b0;
    smp_valid = 1'b0;
    tx_req = 1'b0;
    tx_done = 1'b0;
    clr_ovf = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b);
    smp_data = b;
    smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic req();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
  endtask

  task automatic run_to_send();
    for (int i = 0; i < 10 && tx_start_en !== 1'b1; i++) tick();
    chk("start_seen", 32'(tx_start_en), 32'd1);
    tick();
  endtask

  initial begin
    do_reset();
    chk("rst_start", 32'(tx_start_en), 32'd0);
    chk("rst_data", tx_data, 32'h0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(ovf_flag), 32'd0);
    chk("rst_seq", 32'(seq_num), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("byte_num", 32'(tx_byte_num), 32'd20);
    cap_en = 1'b1;
    feed(8'h01); feed(8'h02); feed(8'h03);
    chk("t1_level3b", 32'(fifo_level), 32'd0);
    feed(8'h04);
    chk("t1_level", 32'(fifo_level), 32'd1);
    chk("t1_ovf", 32'(ovf_flag), 32'd0);
    for (int i = 0; i < 12; i++) feed(8'hEE);
    run_to_send();
    req();
    chk("t1_hdr", tx_data, 32'hA55A0000);
    req();
    chk("t1_head", tx_data, 32'h01020304);

    do_reset();
    s0 = starts;
    cap_en = 1'b1;
    for (int i = 0; i < 16; i++) feed(8'(i));
    chk("t2_level", 32'(fifo_level), 32'd4);
    run_to_send();
    chk("t2_busy_send", 32'(busy), 32'd1);
    req(); chk("t2_w0", tx_data, 32'hA55A0000);
    req(); chk("t2_w1", tx_data, 32'h00010203);
    req(); chk("t2_w2", tx_data, 32'h04050607);
    req(); chk("t2_w3", tx_data, 32'h08090A0B);
    req(); chk("t2_w4", tx_data, 32'h0C0D0E0F);
    tick();
    chk("t2_hold", tx_data, 32'h0C0D0E0F);
    req(); chk("t2_extra_req", tx_data, 32'h0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("t2_seq", 32'(seq_num), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_level_end", 32'(fifo_level), 32'd0);
    chk("t2_starts", 32'(starts - s0), 32'd1);

    do_reset();
    cap_en = 1'b1;
    feed(8'hAA); feed(8'hBB);
    cap_en = 1'b0; tick(); cap_en = 1'b1;
    feed(8'h11); feed(8'h22);
    chk("t3_no_stale_push", 32'(fifo_level), 32'd0);
    feed(8'h33); feed(8'h44);
    chk("t3_level", 32'(fifo_level), 32'd1);
    for (int i = 0; i < 12; i++) feed(8'h5A);
    run_to_send();
    req(); req();
    chk("t3_word", tx_data, 32'h11223344);

    do_reset();
    cap_en = 1'b1;
    for (int i = 0; i < 20; i++) feed(8'(8'h40 + i));
    chk("t4_level", 32'(fifo_level), 32'd4);
    chk("t4_ovf", 32'(ovf_flag), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t4_clr", 32'(ovf_flag), 32'd0);
    feed(8'h70); feed(8'h71); feed(8'h72);
    smp_data = 8'h73; smp_valid = 1'b1; clr_ovf = 1'b1;
    tick();
    smp_valid = 1'b0; clr_ovf = 1'b0;
    chk("t4_set_wins", 32'(ovf_flag), 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t4_clr2", 32'(ovf_flag), 32'd0);
    chk("t4_level2", 32'(fifo_level), 32'd4);

    req(); chk("t5_hdr", tx_data, 32'hA55A0000);
    req(); chk("t5_w1", tx_data, 32'h40414243);
    chk("t5_level3", 32'(fifo_level), 32'd3);
    feed(8'h60); feed(8'h61); feed(8'h62);
    smp_data = 8'h63; smp_valid = 1'b1; tx_req = 1'b1;
    tick();
    smp_valid = 1'b0; tx_req = 1'b0;
    chk("t5_w2", tx_data, 32'h44454647);
    chk("t5_level_same", 32'(fifo_level), 32'd3);
    req(); chk("t5_w3", tx_data, 32'h48494A4B);
    req(); chk("t5_w4", tx_data, 32'h4C4D4E4F);
    chk("t5_level_end", 32'(fifo_level), 32'd1);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("t5_seq", 32'(seq_num), 32'd1);

    do_reset();
    cap_en = 1'b1;
    for (int i = 0; i < 16; i++) feed(8'(i));
    run_to_send();
    req(); chk("t6_hdr", tx_data, 32'hA55A0000);
    req(); chk("t6_w1", tx_data, 32'h00010203);
    s0 = starts;
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    chk("t6_data", tx_data, 32'h0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_seq", 32'(seq_num), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_start", 32'(tx_start_en), 32'd0);
    chk("t6_ovf", 32'(ovf_flag), 32'd0);
    chk("t6_byte_num", 32'(tx_byte_num), 32'd20);
    req(); chk("t6_req_data", tx_data, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_start", 32'(starts - s0), 32'd0);
    chk("t6_busy_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
